// File: rtl/regfile_sb_if.sv
// Register-file bus: operand read ports, issue (mark busy) and writeback (commit) channels.
// ready gates everything: while ready=0 iss_en/wb_en are ignored and reads return 0; otherwise there is no backpressure.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic                 ready;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP-1:0]       rd_busy;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [XLEN-1:0]      wb_data;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard.
// Contents are cleared by a post-reset sweep, one entry per cycle, so the array needs no reset.
module regfile_sb #(
  parameter int  XLEN     = 32,
  parameter int  NREGS    = 32,
  parameter int  NRP      = 2,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus,
  output logic         state_dbg
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              run;
  logic              wb_ok;
  logic              iss_ok;

  assign run       = (state_q == S_RUN);
  assign state_dbg = state_q;
  assign bus.ready = run;

  // Register 0 swallows writes and issues when hardwired to zero.
  assign wb_ok  = run && bus.wb_en  && !((ZERO_REG != 0) && (bus.wb_addr  == '0));
  assign iss_ok = run && bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == AW'(NREGS - 1)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Single write port shared by the init sweep and writeback.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)       mem[ptr_q]       <= '0;
      else if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Issue is applied after writeback so a same-address new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_ok)  busy_d[bus.wb_addr]  = 1'b0;
    if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] d;
    logic            b;

    assign a   = bus.rd_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wb_ok && (bus.wb_addr == a);

    always_comb begin
      d = '0;
      b = 1'b0;
      if (run && !((ZERO_REG != 0) && (a == '0))) begin
        if (hit) begin
          d = bus.wb_data;
        end else begin
          d = mem[a];
          b = busy_q[a];
        end
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = d;
    assign bus.rd_busy[i]              = b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default build (a) and a 64x64, 3-port, no-zero-reg, no-bypass build (b)
// checked every cycle against an array model, plus literal expectations at key points.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- build description ----------------
  function automatic int nregs(int d);  return (d == 0) ? 32 : 64; endfunction
  function automatic int nrp(int d);    return (d == 0) ? 2 : 3;   endfunction
  function automatic bit zero_r(int d); return (d == 0);           endfunction
  function automatic bit byp(int d);    return (d == 0);           endfunction
  function automatic logic [63:0] dmask(int d);
    return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // ---------------- stimulus variables ----------------
  logic        iss_en   [2];
  logic        wb_en    [2];
  logic [5:0]  iss_addr [2];
  logic [5:0]  wb_addr  [2];
  logic [63:0] wb_data  [2];
  logic [5:0]  ra       [2][3];
  logic        chk_en = 1'b0;

  regfile_sb_if #(.XLEN(32), .AW(5), .NRP(2)) if_a ();
  regfile_sb_if #(.XLEN(64), .AW(6), .NRP(3)) if_b ();

  assign if_a.iss_en   = iss_en[0];
  assign if_a.iss_addr = iss_addr[0][4:0];
  assign if_a.wb_en    = wb_en[0];
  assign if_a.wb_addr  = wb_addr[0][4:0];
  assign if_a.wb_data  = wb_data[0][31:0];
  assign if_a.rd_addr  = {ra[0][1][4:0], ra[0][0][4:0]};

  assign if_b.iss_en   = iss_en[1];
  assign if_b.iss_addr = iss_addr[1];
  assign if_b.wb_en    = wb_en[1];
  assign if_b.wb_addr  = wb_addr[1];
  assign if_b.wb_data  = wb_data[1];
  assign if_b.rd_addr  = {ra[1][2], ra[1][1], ra[1][0]};

  logic dbg_a, dbg_b;

  regfile_sb dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if_a),
    .state_dbg (dbg_a)
  );

  regfile_sb #(.XLEN(64), .NREGS(64), .NRP(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if_b),
    .state_dbg (dbg_b)
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem  [2][64];
  logic        m_busy [2][64];
  int          cnt = 0;   // clock edges with rst_n=1 since the last reset edge (saturating)

  always @(posedge clk) begin
    int wa, ia;
    if (!rst_n) begin
      cnt = 0;
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 64; r++) m_busy[d][r] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        wa = int'(wb_addr[d])  & (nregs(d) - 1);
        ia = int'(iss_addr[d]) & (nregs(d) - 1);
        if (cnt >= nregs(d)) begin
          if (wb_en[d] && !(zero_r(d) && wa == 0)) begin
            m_mem[d][wa]  = wb_data[d] & dmask(d);
            m_busy[d][wa] = 1'b0;
          end
          if (iss_en[d] && !(zero_r(d) && ia == 0)) m_busy[d][ia] = 1'b1;
        end
      end
      if (cnt < 1000) cnt = cnt + 1;
      for (int d = 0; d < 2; d++)
        if (cnt == nregs(d))
          for (int r = 0; r < 64; r++) begin
            m_mem[d][r]  = '0;
            m_busy[d][r] = 1'b0;
          end
    end
  end

  // {busy, data} that port p of build d must show right now
  function automatic logic [64:0] exp_rd(int d, int p);
    int a, wa;
    a  = int'(ra[d][p])     & (nregs(d) - 1);
    wa = int'(wb_addr[d])   & (nregs(d) - 1);
    if (cnt < nregs(d))                        return '0;
    if (zero_r(d) && a == 0)                   return '0;
    if (byp(d) && wb_en[d] && wa == a)         return {1'b0, wb_data[d] & dmask(d)};
    return {m_busy[d][a], m_mem[d][a]};
  endfunction

  // ---------------- DUT observation ----------------
  function automatic logic [63:0] rdd(int d, int p);
    if (d == 0) return {32'h0, if_a.rd_data[p*32 +: 32]};
    return if_b.rd_data[p*64 +: 64];
  endfunction

  function automatic logic rdb(int d, int p);
    if (d == 0) return if_a.rd_busy[p];
    return if_b.rd_busy[p];
  endfunction

  function automatic logic rdy(int d);
    return (d == 0) ? if_a.ready : if_b.ready;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("ready_d%0d", d), {63'h0, rdy(d)}, {63'h0, (cnt >= nregs(d))});
        cmp($sformatf("state_d%0d", d), {63'h0, (d == 0) ? dbg_a : dbg_b}, {63'h0, (cnt >= nregs(d))});
        for (int p = 0; p < nrp(d); p++) begin
          e = exp_rd(d, p);
          cmp($sformatf("rd_data_d%0d_p%0d", d, p), rdd(d, p), e[63:0]);
          cmp($sformatf("rd_busy_d%0d_p%0d", d, p), {63'h0, rdb(d, p)}, {63'h0, e[64]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int d);
    iss_en[d]   = 1'b0;
    wb_en[d]    = 1'b0;
    iss_addr[d] = '0;
    wb_addr[d]  = '0;
    wb_data[d]  = '0;
  endtask

  task automatic wb(int d, int a, logic [63:0] v);
    wb_en[d]   = 1'b1;
    wb_addr[d] = 6'(a);
    wb_data[d] = v;
  endtask

  task automatic iss(int d, int a);
    iss_en[d]   = 1'b1;
    iss_addr[d] = 6'(a);
  endtask

  // directed mixed vectors: {iss_en, iss_addr, wb_en, wb_addr, data, ra0, ra1}
  typedef struct {
    logic        ie;
    int          ia;
    logic        we;
    int          wa;
    logic [63:0] wd;
    int          r0;
    int          r1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 12, 1'b1, 13, 64'h1111_2222_3333_4444, 12, 13};
    vecs[1] = '{1'b1, 13, 1'b0,  0, 64'h0,                   13, 12};
    vecs[2] = '{1'b0,  0, 1'b1, 12, 64'hA5A5_A5A5_5A5A_5A5A, 12, 13};
    vecs[3] = '{1'b1, 31, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31};
    vecs[4] = '{1'b0,  0, 1'b1, 13, 64'h0000_0000_0000_0001, 13, 31};
    vecs[5] = '{1'b1,  1, 1'b1,  1, 64'h8000_0000_8000_0000,  1,  0};
    vecs[6] = '{1'b0,  0, 1'b1, 31, 64'h0123_4567_89AB_CDEF, 31,  1};
    vecs[7] = '{1'b0,  0, 1'b0,  0, 64'h0,                    1, 12};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      idle(d);
      for (int p = 0; p < 3; p++) ra[d][p] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // init sweep with enables held high: nothing may be written or marked busy
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iss(d, 5);
      wb(d, 5, 64'hFFFF_FFFF_FFFF_FFFF);
      ra[d][0] = 6'd5;
    end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 31) begin
        cmp("init_a_ready_lo", {63'h0, rdy(0)}, 64'd0);
        idle(0);
      end
      if (i == 32) begin
        cmp("init_a_ready_hi", {63'h0, rdy(0)}, 64'd1);
        cmp("init_b_ready_lo", {63'h0, rdy(1)}, 64'd0);
        cmp("init_a_x5_zero",  rdd(0, 0), 64'd0);
        cmp("init_a_x5_idle",  {63'h0, rdb(0, 0)}, 64'd0);
      end
      if (i == 63) begin
        cmp("init_b_ready_lo63", {63'h0, rdy(1)}, 64'd0);
        idle(1);
      end
      if (i == 64) begin
        cmp("init_b_ready_hi", {63'h0, rdy(1)}, 64'd1);
        cmp("init_b_x5_zero",  rdd(1, 0), 64'd0);
      end
    end

    // write then read; x0 write dropped on build a
    wb(0, 5, 64'hDEAD_BEEF);
    tick();
    idle(0);
    ra[0][0] = 6'd5;
    ra[0][1] = 6'd0;
    wb(0, 0, 64'h1);
    #1;
    cmp("wr_a_x5", rdd(0, 0), 64'hDEAD_BEEF);
    cmp("wr_a_x0", rdd(0, 1), 64'h0);
    tick();
    idle(0);

    // bypass on build a
    wb(0, 7, 64'h1234_5678);
    ra[0][0] = 6'd7;
    ra[0][1] = 6'd7;
    #1;
    cmp("byp_a_p0", rdd(0, 0), 64'h1234_5678);
    cmp("byp_a_p1", rdd(0, 1), 64'h1234_5678);
    cmp("byp_a_busy", {63'h0, rdb(0, 0)}, 64'd0);
    tick();
    idle(0);

    // no bypass on build b: old value until the edge
    wb(1, 7, 64'hAAAA);
    tick();
    wb(1, 7, 64'h1234_5678);
    ra[1][0] = 6'd7;
    ra[1][1] = 6'd7;
    #1;
    cmp("nobyp_b_p0", rdd(1, 0), 64'hAAAA);
    cmp("nobyp_b_p1", rdd(1, 1), 64'hAAAA);
    tick();
    idle(1);
    #1;
    cmp("nobyp_b_after", rdd(1, 0), 64'h1234_5678);

    // x0 is ordinary on build b
    wb(1, 0, 64'h1);
    tick();
    idle(1);
    ra[1][2] = 6'd0;
    #1;
    cmp("b_x0_writable", rdd(1, 2), 64'h1);

    // scoreboard on build a
    iss(0, 9);
    ra[0][0] = 6'd9;
    #1;
    cmp("sb_a_iss_same_cyc", {63'h0, rdb(0, 0)}, 64'd0);
    tick();
    idle(0);
    #1;
    cmp("sb_a_busy_set", {63'h0, rdb(0, 0)}, 64'd1);
    wb(0, 9, 64'h99);
    #1;
    cmp("sb_a_wb_byp_busy", {63'h0, rdb(0, 0)}, 64'd0);
    cmp("sb_a_wb_byp_data", rdd(0, 0), 64'h99);
    tick();
    idle(0);
    #1;
    cmp("sb_a_busy_clr", {63'h0, rdb(0, 0)}, 64'd0);
    iss(0, 9);
    wb(0, 9, 64'h55);
    tick();
    idle(0);
    #1;
    cmp("sb_a_iss_wb_busy", {63'h0, rdb(0, 0)}, 64'd1);
    cmp("sb_a_iss_wb_data", rdd(0, 0), 64'h55);

    // register 0 never busy on build a
    iss(0, 0);
    tick();
    idle(0);
    ra[0][1] = 6'd0;
    #1;
    cmp("sb_a_x0_busy", {63'h0, rdb(0, 1)}, 64'd0);

    // build b without bypass: busy visible until after the writeback edge
    iss(1, 9);
    tick();
    idle(1);
    wb(1, 9, 64'h77);
    ra[1][1] = 6'd9;
    #1;
    cmp("sb_b_busy_during_wb", {63'h0, rdb(1, 1)}, 64'd1);
    tick();
    idle(1);
    #1;
    cmp("sb_b_busy_clr", {63'h0, rdb(1, 1)}, 64'd0);
    cmp("sb_b_data", rdd(1, 1), 64'h77);

    // three independent 64-bit ports on build b
    wb(1, 10, 64'h0123_4567_89AB_CDEF);
    tick();
    wb(1, 20, 64'hFEDC_BA98_7654_3210);
    tick();
    wb(1, 63, 64'h8000_0000_0000_0001);
    tick();
    idle(1);
    ra[1][0] = 6'd10;
    ra[1][1] = 6'd20;
    ra[1][2] = 6'd63;
    #1;
    cmp("b3_p0", rdd(1, 0), 64'h0123_4567_89AB_CDEF);
    cmp("b3_p1", rdd(1, 1), 64'hFEDC_BA98_7654_3210);
    cmp("b3_p2", rdd(1, 2), 64'h8000_0000_0000_0001);

    // mixed vectors on both builds, checked by the model every cycle
    for (int v = 0; v < 8; v++) begin
      for (int d = 0; d < 2; d++) begin
        iss_en[d]   = vecs[v].ie;
        iss_addr[d] = 6'(vecs[v].ia);
        wb_en[d]    = vecs[v].we;
        wb_addr[d]  = 6'(vecs[v].wa);
        wb_data[d]  = vecs[v].wd;
        ra[d][0]    = 6'(vecs[v].r0);
        ra[d][1]    = 6'(vecs[v].r1);
      end
      tick();
    end
    idle(0);
    idle(1);

    // reset in the middle of RUN
    wb(0, 3, 64'h33);
    tick();
    idle(0);
    iss(0, 3);
    tick();
    idle(0);
    ra[0][0] = 6'd3;
    #1;
    cmp("rst_a_pre_busy", {63'h0, rdb(0, 0)}, 64'd1);
    cmp("rst_a_pre_data", rdd(0, 0), 64'h33);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    cmp("rst_a_ready", {63'h0, rdy(0)}, 64'd0);
    cmp("rst_a_busy",  {63'h0, rdb(0, 0)}, 64'd0);
    repeat (31) tick();
    cmp("rst_a_ready_lo31", {63'h0, rdy(0)}, 64'd0);
    tick();
    cmp("rst_a_ready_hi", {63'h0, rdy(0)}, 64'd1);
    cmp("rst_a_x3_zero",  rdd(0, 0), 64'd0);
    cmp("rst_a_x3_idle",  {63'h0, rdb(0, 0)}, 64'd0);
    repeat (33) tick();
    cmp("rst_b_ready_hi", {63'h0, rdy(1)}, 64'd1);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
